mem_access_stage: RTL and testbench

- MEM stage of the RV32IM pipeline, directly downstream of the execute stage; consumes the ALU Result as effective address or as pass-through writeback data.
- Drives a single-outstanding req/ack data-memory port. Performs byte/half/word store lane steering and load extraction with sign/zero extension.
- Detects misaligned and illegal accesses and bus timeouts. Stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/mem_access_stage.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32IM pipeline: single-outstanding req/ack data-memory port,
// store lane steering, load extraction, misalign/illegal/timeout detection.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        flush,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_misalign,
  output logic        exc_access,
  output logic [31:0] exc_addr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        misalign;
    logic        access;
    logic [31:0] addr;
  } wb_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  // Captured memory op
  logic [4:0]         cap_rd, cap_rd_n;
  logic               cap_reg_write, cap_reg_write_n;
  logic [2:0]         cap_f3, cap_f3_n;
  logic [31:0]        cap_addr, cap_addr_n;

  // One-entry buffer for a local op that collides with a memory retirement
  logic               buf_v, buf_v_n;
  wb_t                buf_q, buf_n;

  logic               req_n, we_n;
  logic [31:0]        addr_n, wdata_n;
  logic [3:0]         wstrb_n;

  logic               ret_v;
  wb_t                ret;

  logic               is_mem, illegal, misalign, load_ok, store_ok;
  logic               accept, acc_bus, acc_local, tmo, acked;
  wb_t                loc_wb, mem_wb, tmo_wb;
  logic [31:0]        lane_wdata, load_val;
  logic [3:0]         lane_wstrb;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;

  assign stall_out = (state == REQ) && !dmem_ack;
  assign acked     = (state == REQ) && dmem_ack;
  assign tmo       = (state == REQ) && !dmem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Decode of the EX op
  always_comb begin
    is_mem    = ex_mem_read || ex_mem_write;
    load_ok   = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
    store_ok  = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
    illegal   = is_mem && ((ex_mem_read && ex_mem_write) ||
                           (ex_mem_read && !load_ok) || (ex_mem_write && !store_ok));
    misalign  = is_mem && !illegal &&
                (((ex_funct3[1:0] == 2'b01) && ex_result[0]) ||
                 ((ex_funct3[1:0] == 2'b10) && (ex_result[1:0] != 2'b00)));
    accept    = ex_valid && !flush && !stall_out;
    acc_bus   = accept && is_mem && !illegal && !misalign;
    acc_local = accept && !acc_bus;

    loc_wb.reg_write = !is_mem && ex_reg_write;
    loc_wb.rd        = ex_rd;
    loc_wb.data      = is_mem ? 32'h0 : ex_result;
    loc_wb.misalign  = misalign;
    loc_wb.access    = illegal;
    loc_wb.addr      = ex_result;
  end

  // Store lane steering
  always_comb begin
    lane_wdata = ex_store_data;
    lane_wstrb = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        lane_wdata = {4{ex_store_data[7:0]}};
        lane_wstrb = 4'b0001 << ex_result[1:0];
      end
      2'b01: begin
        lane_wdata = {2{ex_store_data[15:0]}};
        lane_wstrb = ex_result[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!ex_mem_write) lane_wstrb = 4'b0000;
  end

  // Load extraction and retirement bundles for memory ops
  always_comb begin
    case (cap_addr[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = cap_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (cap_f3)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_val = {24'h0, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_val = {16'h0, ld_half};
      default: load_val = dmem_rdata;
    endcase

    mem_wb.reg_write = !dmem_we && cap_reg_write;
    mem_wb.rd        = cap_rd;
    mem_wb.data      = dmem_we ? 32'h0 : load_val;
    mem_wb.misalign  = 1'b0;
    mem_wb.access    = 1'b0;
    mem_wb.addr      = cap_addr;

    tmo_wb.reg_write = 1'b0;
    tmo_wb.rd        = cap_rd;
    tmo_wb.data      = 32'h0;
    tmo_wb.misalign  = 1'b0;
    tmo_wb.access    = 1'b1;
    tmo_wb.addr      = cap_addr;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // FSM next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (acc_bus) state_n = REQ;
      REQ: begin
        if (dmem_ack)  state_n = acc_bus ? REQ : IDLE;
        else if (tmo)  state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Next values of registered outputs and capture state
  always_comb begin
    ret_v           = 1'b0;
    ret             = '0;
    buf_v_n         = buf_v;
    buf_n           = buf_q;
    req_n           = dmem_req;
    we_n            = dmem_we;
    addr_n          = dmem_addr;
    wdata_n         = dmem_wdata;
    wstrb_n         = dmem_wstrb;
    cap_rd_n        = cap_rd;
    cap_reg_write_n = cap_reg_write;
    cap_f3_n        = cap_f3;
    cap_addr_n      = cap_addr;
    cnt_n           = cnt;

    // Memory retirement has priority; a colliding local op is delayed one edge
    if (acked) begin
      ret_v = 1'b1;
      ret   = mem_wb;
      if (acc_local) begin
        buf_v_n = 1'b1;
        buf_n   = loc_wb;
      end
    end else if (tmo) begin
      ret_v = 1'b1;
      ret   = tmo_wb;
    end else if (buf_v) begin
      ret_v   = 1'b1;
      ret     = buf_q;
      buf_v_n = acc_local;
      if (acc_local) buf_n = loc_wb;
    end else if (acc_local) begin
      ret_v = 1'b1;
      ret   = loc_wb;
    end

    if (acc_bus) begin
      req_n           = 1'b1;
      we_n            = ex_mem_write;
      addr_n          = {ex_result[31:2], 2'b00};
      wdata_n         = lane_wdata;
      wstrb_n         = lane_wstrb;
      cap_rd_n        = ex_rd;
      cap_reg_write_n = ex_reg_write;
      cap_f3_n        = ex_funct3;
      cap_addr_n      = ex_result;
      cnt_n           = '0;
    end else if (acked || tmo) begin
      req_n = 1'b0;
    end else if (state == REQ) begin
      cnt_n = cnt + CNT_W'(1);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      cap_rd        <= '0;
      cap_reg_write <= 1'b0;
      cap_f3        <= '0;
      cap_addr      <= '0;
      buf_v         <= 1'b0;
      buf_q         <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_wstrb    <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      exc_misalign  <= 1'b0;
      exc_access    <= 1'b0;
      exc_addr      <= '0;
    end else begin
      cnt           <= cnt_n;
      cap_rd        <= cap_rd_n;
      cap_reg_write <= cap_reg_write_n;
      cap_f3        <= cap_f3_n;
      cap_addr      <= cap_addr_n;
      buf_v         <= buf_v_n;
      buf_q         <= buf_n;
      dmem_req      <= req_n;
      dmem_we       <= we_n;
      dmem_addr     <= addr_n;
      dmem_wdata    <= wdata_n;
      dmem_wstrb    <= wstrb_n;
      wb_valid      <= ret_v;
      wb_reg_write  <= ret_v && ret.reg_write;
      exc_misalign  <= ret_v && ret.misalign;
      exc_access    <= ret_v && ret.access;
      if (ret_v) begin
        wb_rd   <= ret.rd;
        wb_data <= ret.data;
      end
      if (ret_v && (ret.misalign || ret.access)) exc_addr <= ret.addr;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed table-driven bench for mem_access_stage with hand-written multi-cycle sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, flush;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        stall_out, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, wb_reg_write, exc_misalign, exc_access;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;

  int n_chk = 0;
  int n_err = 0;
  int wb_cnt;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .flush(flush),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_misalign(exc_misalign), .exc_access(exc_access), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] res;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        regw;
    logic        exp_bus;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic        exp_rw;
    logic        exp_mis;
    logic        exp_acc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0;
    ex_result = 0; ex_store_data = 0; ex_rd = 0; ex_reg_write = 0; flush = 0;
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw);
    ex_valid = 1; ex_mem_read = r; ex_mem_write = w; ex_funct3 = f3;
    ex_result = res; ex_store_data = sd; ex_rd = rd; ex_reg_write = rw;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.rd_en, v.wr_en, v.f3, v.res, v.sdata, v.rd, v.regw);
    @(posedge clk); #1;
    idle_inputs();
    if (v.exp_bus) begin
      chk({v.name, " req"}, 32'(dmem_req), 32'd1);
      chk({v.name, " addr"}, dmem_addr, {v.res[31:2], 2'b00});
      chk({v.name, " we"}, 32'(dmem_we), 32'(v.wr_en));
      chk({v.name, " wstrb"}, 32'(dmem_wstrb), 32'(v.exp_strb));
      if (v.wr_en) chk({v.name, " wdata"}, dmem_wdata, v.exp_wdata);
      chk({v.name, " stall"}, 32'(stall_out), 32'd1);
      @(negedge clk);
      dmem_ack = 1; dmem_rdata = v.rdata;
      #1 chk({v.name, " stall_ack"}, 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      dmem_ack = 0;
      chk({v.name, " req_drop"}, 32'(dmem_req), 32'd0);
      chk({v.name, " wb_valid"}, 32'(wb_valid), 32'd1);
      chk({v.name, " wb_rw"}, 32'(wb_reg_write), 32'(v.exp_rw));
      chk({v.name, " wb_data"}, wb_data, v.exp_data);
      chk({v.name, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
    end else begin
      chk({v.name, " no_req"}, 32'(dmem_req), 32'd0);
      chk({v.name, " wb_valid"}, 32'(wb_valid), 32'd1);
      chk({v.name, " wb_rw"}, 32'(wb_reg_write), 32'(v.exp_rw));
      chk({v.name, " mis"}, 32'(exc_misalign), 32'(v.exp_mis));
      chk({v.name, " acc"}, 32'(exc_access), 32'(v.exp_acc));
      if (v.exp_mis || v.exp_acc) chk({v.name, " exc_addr"}, exc_addr, v.res);
      else                        chk({v.name, " wb_data"}, wb_data, v.exp_data);
    end
    @(posedge clk); #1;
    chk({v.name, " pulse_end"}, 32'(wb_valid), 32'd0);
  endtask

  function automatic vec_t mk(string nm, logic r, logic w, logic [2:0] f3, logic [31:0] res,
                              logic [31:0] sd, logic [31:0] rdat, logic bus, logic [3:0] strb,
                              logic [31:0] wd, logic [31:0] dat, logic rw, logic mis, logic acc);
    vec_t v;
    v.name = nm; v.rd_en = r; v.wr_en = w; v.f3 = f3; v.res = res; v.sdata = sd;
    v.rdata = rdat; v.rd = 5'd5; v.regw = 1'b1; v.exp_bus = bus; v.exp_strb = strb;
    v.exp_wdata = wd; v.exp_data = dat; v.exp_rw = rw; v.exp_mis = mis; v.exp_acc = acc;
    return v;
  endfunction

  initial begin
    idle_inputs();
    dmem_ack = 0; dmem_rdata = 0; rst_n = 0;
    vecs.push_back(mk("lb",   1,0,3'b000,32'h1003,0,32'h80FF1234,1,4'b0000,0,32'hFFFFFF80,1,0,0));
    vecs.push_back(mk("lbu",  1,0,3'b100,32'h1003,0,32'h80FF1234,1,4'b0000,0,32'h00000080,1,0,0));
    vecs.push_back(mk("lh",   1,0,3'b001,32'h1002,0,32'h80FF1234,1,4'b0000,0,32'hFFFF80FF,1,0,0));
    vecs.push_back(mk("lhu",  1,0,3'b101,32'h1000,0,32'h80FF1234,1,4'b0000,0,32'h00001234,1,0,0));
    vecs.push_back(mk("lw",   1,0,3'b010,32'h2000,0,32'hDEADBEEF,1,4'b0000,0,32'hDEADBEEF,1,0,0));
    vecs.push_back(mk("sb",   0,1,3'b000,32'h2001,32'h12345678,0,1,4'b0010,32'h78787878,0,0,0,0));
    vecs.push_back(mk("sw",   0,1,3'b010,32'h2004,32'hCAFEF00D,0,1,4'b1111,32'hCAFEF00D,0,0,0,0));
    vecs.push_back(mk("alu",  0,0,3'b000,32'h12345678,0,0,0,4'b0000,0,32'h12345678,1,0,0));
    vecs.push_back(mk("lw_mis",1,0,3'b010,32'h3001,0,0,0,4'b0000,0,0,0,1,0));
    vecs.push_back(mk("lh_mis",1,0,3'b001,32'h3003,0,0,0,4'b0000,0,0,0,1,0));
    vecs.push_back(mk("f3_011",1,0,3'b011,32'h4000,0,0,0,4'b0000,0,0,0,0,1));
    vecs.push_back(mk("rw_both",1,1,3'b010,32'h4004,0,0,0,4'b0000,0,0,0,0,1));
    vecs.push_back(mk("sbu_ill",0,1,3'b100,32'h4008,0,0,0,4'b0000,0,0,0,0,1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst req", 32'(dmem_req), 32'd0);
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst addr", dmem_addr, 32'd0);
    chk("rst exc", 32'({exc_misalign, exc_access}), 32'd0);
    @(negedge clk); rst_n = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // SH with ack after 3 stall cycles
    @(negedge clk);
    drive(0, 1, 3'b001, 32'h2002, 32'h0000BEEF, 5'd6, 1'b1);
    @(posedge clk); #1; idle_inputs();
    chk("sh wstrb", 32'(dmem_wstrb), 32'hC);
    chk("sh wdata", dmem_wdata, 32'hBEEFBEEF);
    for (int c = 0; c < 3; c++) begin
      chk("sh stall", 32'(stall_out), 32'd1);
      @(posedge clk); #1;
    end
    dmem_ack = 1;
    @(posedge clk); #1; dmem_ack = 0;
    chk("sh wb_valid", 32'(wb_valid), 32'd1);
    chk("sh wb_rw", 32'(wb_reg_write), 32'd0);

    // Back-to-back LW then SW, each acked on its first REQ cycle
    @(negedge clk);
    drive(1, 0, 3'b010, 32'h10, 0, 5'd3, 1'b1);
    @(posedge clk); #1;
    chk("b2b req1", 32'(dmem_req), 32'd1);
    drive(0, 1, 3'b010, 32'h14, 32'h55AA55AA, 5'd0, 1'b0);
    dmem_ack = 1; dmem_rdata = 32'h11111111;
    @(posedge clk); #1;
    idle_inputs();
    wb_cnt = int'(wb_valid);
    chk("b2b wb1 data", wb_data, 32'h11111111);
    chk("b2b req2", 32'(dmem_req), 32'd1);
    chk("b2b addr2", dmem_addr, 32'h14);
    chk("b2b we2", 32'(dmem_we), 32'd1);
    @(posedge clk); #1; dmem_ack = 0;
    wb_cnt += int'(wb_valid);
    chk("b2b wb2 rw", 32'(wb_reg_write), 32'd0);
    chk("b2b req_end", 32'(dmem_req), 32'd0);
    chk("b2b wb_count", 32'(wb_cnt), 32'd2);

    // Memory ack collides with an ALU op: ALU result retires one edge later
    @(negedge clk);
    drive(1, 0, 3'b010, 32'h50, 0, 5'd3, 1'b1);
    @(posedge clk); #1;
    drive(0, 0, 3'b000, 32'h77, 0, 5'd9, 1'b1);
    dmem_ack = 1; dmem_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1; idle_inputs(); dmem_ack = 0;
    chk("coll mem_data", wb_data, 32'hA5A5A5A5);
    chk("coll mem_rd", 32'(wb_rd), 32'd3);
    @(posedge clk); #1;
    chk("coll alu_valid", 32'(wb_valid), 32'd1);
    chk("coll alu_data", wb_data, 32'h77);
    chk("coll alu_rd", 32'(wb_rd), 32'd9);
    @(posedge clk); #1;
    chk("coll quiet", 32'(wb_valid), 32'd0);

    // Timeout with TIMEOUT_CYCLES=4, then a stray ack
    @(negedge clk);
    drive(1, 0, 3'b010, 32'h40, 0, 5'd4, 1'b1);
    @(posedge clk); #1; idle_inputs();
    for (int c = 0; c < 3; c++) begin
      chk("tmo req_held", 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
    end
    chk("tmo req_last", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    chk("tmo req_drop", 32'(dmem_req), 32'd0);
    chk("tmo wb_valid", 32'(wb_valid), 32'd1);
    chk("tmo exc_acc", 32'(exc_access), 32'd1);
    chk("tmo exc_addr", exc_addr, 32'h40);
    chk("tmo wb_rw", 32'(wb_reg_write), 32'd0);
    dmem_ack = 1;
    @(posedge clk); #1; dmem_ack = 0;
    chk("stray wb", 32'(wb_valid), 32'd0);
    chk("stray req", 32'(dmem_req), 32'd0);

    // Reset while a request is outstanding
    @(negedge clk);
    drive(0, 1, 3'b010, 32'h60, 32'hFFFFFFFF, 5'd0, 1'b0);
    @(posedge clk); #1; idle_inputs();
    chk("rreq req", 32'(dmem_req), 32'd1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("rreq req0", 32'(dmem_req), 32'd0);
    chk("rreq strb0", 32'(dmem_wstrb), 32'd0);
    chk("rreq wdata0", dmem_wdata, 32'd0);
    chk("rreq wb0", 32'(wb_valid), 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rreq no_wb", 32'(wb_valid), 32'd0);
    chk("rreq stall", 32'(stall_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
